// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, the
// RMW FSM encoding and the sub-word lane merge used to build store words.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Replace the addressed byte/half of word with the low bits of data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  funct3);
        logic [31:0] r;
        r = word;
        if (funct3 == F3_B)
            r[{addr_lo, 3'b000} +: 8] = data[7:0];
        else if (funct3 == F3_H)
            r[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
        else
            r = data;
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane extraction and sign/zero extension of a read word for RV32 loads.
// Purely combinational so the forwarding path can reuse it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v      = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'b0, byte_v};
            F3_HU:   load_data_o = {16'b0, half_v};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu_rmw.sv
// MEM-stage load/store unit: word-aligned loads with lane extraction, and
// SB/SH turned into a read-modify-write that stalls the pipeline one cycle.
module mem_lsu_rmw
    import lsu_pkg::*;
#(
    parameter int WIDTH_ADDR = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  stall,
    output logic                  misalign_exc
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   wbuf_q, wbuf_d;
    logic [WIDTH_ADDR-1:0]   waddr_q, waddr_d;

    logic [WIDTH_ADDR-1:0]   word_idx;
    logic [1:0]              addr_lo;
    logic                    ld_legal, st_legal, legal, misalign, ok;
    logic [DATA_WIDTH-1:0]   aligned;
    logic                    unused_addr_hi;

    // Upper address bits are dropped: the word index wraps over the memory.
    assign word_idx       = req_addr[WIDTH_ADDR+1:2];
    assign addr_lo        = req_addr[1:0];
    assign unused_addr_hi = &{1'b0, req_addr[31:WIDTH_ADDR+2]};

    assign ld_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                      (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    assign st_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    assign legal    = req_we ? st_legal : ld_legal;
    assign misalign = legal && (((req_funct3[1:0] == 2'b01) && addr_lo[0]) ||
                                ((req_funct3 == F3_W) && (addr_lo != 2'b00)));
    assign ok       = req_valid && legal && !misalign;

    lsu_load_align u_align (
        .rdata_i     (mem_rdata),
        .addr_lo_i   (addr_lo),
        .funct3_i    (req_funct3),
        .load_data_o (aligned)
    );

    always_comb begin
        state_d      = state_q;
        wbuf_d       = wbuf_q;
        waddr_d      = waddr_q;
        mem_addr     = word_idx;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        load_data    = '0;
        stall        = 1'b0;
        misalign_exc = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && misalign) begin
                    misalign_exc = 1'b1;
                end else if (ok && req_we) begin
                    if (req_funct3 == F3_W) begin
                        mem_we    = 1'b1;
                        mem_wdata = req_wdata;
                    end else begin
                        stall   = 1'b1;
                        wbuf_d  = lane_merge(mem_rdata, req_wdata, addr_lo, req_funct3);
                        waddr_d = word_idx;
                        state_d = WRITE;
                    end
                end else if (ok) begin
                    load_data = aligned;
                end
            end
            // The pipeline re-presents the same store here, so inputs are ignored.
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = wbuf_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            mem_we       = 1'b0;
            mem_wdata    = '0;
            stall        = 1'b0;
            misalign_exc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wbuf_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// Directed bench for mem_lsu_rmw with a behavioural word memory; expected
// per-cycle responses go into a queue that a negedge monitor drains.
module tb_mem_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  mem_addr;
    logic        mem_we, stall, misalign_exc;
    logic [31:0] mem_wdata, mem_rdata, load_data;
    logic [31:0] mem [256];

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    always #5 clk = ~clk;

    mem_lsu_rmw #(.WIDTH_ADDR(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_data(load_data), .stall(stall),
        .misalign_exc(misalign_exc)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        string       nm;
        bit          c_ld;   logic [31:0] ld;
        bit          c_ctl;  logic st, we, mx;
        bit          c_addr; logic [7:0] a;
        bit          c_wd;   logic [31:0] wd;
        bit          c_mem;  int idx; logic [31:0] mv;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    function automatic exp_t blank(input string nm);
        exp_t e;
        e.nm = nm; e.c_ld = 0; e.ld = '0; e.c_ctl = 0; e.st = 0; e.we = 0; e.mx = 0;
        e.c_addr = 0; e.a = '0; e.c_wd = 0; e.wd = '0; e.c_mem = 0; e.idx = 0; e.mv = '0;
        return e;
    endfunction

    task automatic e_ctl(input string nm, input logic st, input logic we, input logic mx);
        exp_t e = blank(nm);
        e.c_ctl = 1; e.st = st; e.we = we; e.mx = mx;
        q.push_back(e);
    endtask

    task automatic e_load(input string nm, input logic [31:0] ld);
        exp_t e = blank(nm);
        e.c_ld = 1; e.ld = ld; e.c_ctl = 1;
        q.push_back(e);
    endtask

    task automatic e_load_at(input string nm, input logic [7:0] a, input logic [31:0] ld);
        exp_t e = blank(nm);
        e.c_ld = 1; e.ld = ld; e.c_ctl = 1; e.c_addr = 1; e.a = a;
        q.push_back(e);
    endtask

    task automatic e_mis(input string nm);
        exp_t e = blank(nm);
        e.c_ld = 1; e.c_ctl = 1; e.mx = 1;
        q.push_back(e);
    endtask

    task automatic e_wr(input string nm, input logic [7:0] a, input logic [31:0] wd);
        exp_t e = blank(nm);
        e.c_ctl = 1; e.we = 1; e.c_addr = 1; e.a = a; e.c_wd = 1; e.wd = wd;
        q.push_back(e);
    endtask

    task automatic e_mem(input string nm, input int idx, input logic [31:0] mv);
        exp_t e = blank(nm);
        e.c_mem = 1; e.idx = idx; e.mv = mv;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.c_ld)   chk(e.nm, "load_data", load_data, e.ld);
            if (e.c_ctl) begin
                chk(e.nm, "stall", {31'b0, stall}, {31'b0, e.st});
                chk(e.nm, "mem_we", {31'b0, mem_we}, {31'b0, e.we});
                chk(e.nm, "misalign_exc", {31'b0, misalign_exc}, {31'b0, e.mx});
                if (!e.we) chk(e.nm, "mem_wdata_idle", mem_wdata, 32'h0);
            end
            if (e.c_addr) chk(e.nm, "mem_addr", {24'b0, mem_addr}, {24'b0, e.a});
            if (e.c_wd)   chk(e.nm, "mem_wdata", mem_wdata, e.wd);
            if (e.c_mem)  chk(e.nm, "mem_word", mem[e.idx], e.mv);
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    endtask

    task automatic preset(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        mem[idx] = val;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'h11223344;

        // Reset held with an SB presented: nothing may be written or stalled.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, B, 32'h0, 32'hAB);
            e_ctl("rst_hold", 0, 0, 0);
        end
        drive(1, 1, B, 32'h0, 32'hAB); rst_n = 1'b1;
        e_ctl("rst_idle", 1, 0, 0);
        drive(1, 1, B, 32'h0, 32'hAB);
        e_wr("rst_sb_wr", 8'd0, 32'h0000_00AB);
        drive(0, 0, B, 32'h0, 32'h0);
        e_mem("rst_sb_mem", 0, 32'h0000_00AB);

        drive(1, 0, B,  32'h07, 0); e_load("lb_07", 32'h0000_0011);
        drive(1, 0, BU, 32'h04, 0); e_load("lbu_04", 32'h0000_0044);
        drive(1, 0, H,  32'h06, 0); e_load("lh_06", 32'h0000_1122);

        preset(1, 32'h80FF7F00);
        drive(1, 0, B,  32'h06, 0); e_load("lb_06_neg", 32'hFFFF_FFFF);
        drive(1, 0, HU, 32'h06, 0); e_load("lhu_06", 32'h0000_80FF);
        drive(1, 0, H,  32'h06, 0); e_load("lh_06_neg", 32'hFFFF_80FF);
        drive(1, 0, W,  32'h404, 0); e_load_at("lw_wrap", 8'd1, 32'h80FF_7F00);

        preset(2, 32'hAABBCCDD);
        drive(1, 1, B, 32'h09, 32'h55); e_ctl("sb_T", 1, 0, 0);
        drive(1, 1, B, 32'h09, 32'h55); e_wr("sb_T1", 8'd2, 32'hAABB_55DD);
        drive(0, 0, B, 32'h0, 0);       e_mem("sb_mem", 2, 32'hAABB_55DD);

        drive(1, 1, H, 32'h03, 32'hBEEF); e_mis("sh_mis");
        drive(1, 0, W, 32'h02, 0);        e_mis("lw_mis");
        drive(0, 0, B, 32'h0, 0);         e_mem("mis_mem", 0, 32'h0000_00AB);

        drive(1, 1, W, 32'h0C, 32'hCAFEF00D); e_wr("sw", 8'd3, 32'hCAFE_F00D);
        drive(1, 1, 3'b011, 32'h0C, 32'h0);   e_ctl("ill_st", 0, 0, 0);
        drive(1, 0, 3'b110, 32'h04, 32'h0);   e_load("ill_ld", 32'h0);
        drive(0, 0, B, 32'h0, 0);             e_mem("sw_mem", 3, 32'hCAFE_F00D);

        preset(2, 32'h0);
        drive(1, 1, B, 32'h08, 32'h12); e_ctl("b2b_1T", 1, 0, 0);
        drive(1, 1, B, 32'h08, 32'h12); e_wr("b2b_1W", 8'd2, 32'h0000_0012);
        drive(1, 1, B, 32'h0B, 32'h34); e_ctl("b2b_2T", 1, 0, 0);
        drive(1, 1, B, 32'h0B, 32'h34); e_wr("b2b_2W", 8'd2, 32'h3400_0012);
        drive(1, 0, W, 32'h08, 0);      e_load("b2b_lw", 32'h3400_0012);

        preset(3, 32'h01020304);
        drive(1, 1, B, 32'h0C, 32'hFF); e_ctl("rstw_T", 1, 0, 0);
        drive(1, 1, B, 32'h0C, 32'hFF); rst_n = 1'b0;
        e_ctl("rstw_drop", 0, 0, 0);
        drive(1, 0, W, 32'h0C, 0); rst_n = 1'b1;
        e_load("rstw_lw", 32'h0102_0304);
        drive(0, 0, B, 32'h0, 0);  e_mem("rstw_mem", 3, 32'h0102_0304);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
